// File: rtl/mux_scan.sv
// N-channel registered mux with manual select and masked auto-scan.
// Channel decode is built from a chain of per-channel lanes; scan advance picks the nearest enabled channel.

module mux_scan_lane #(
  parameter int W   = 1,
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic [SW-1:0] sel,
  input  logic [W-1:0]  d,
  input  logic          m,
  input  logic [W-1:0]  d_acc,
  input  logic          m_acc,
  output logic [W-1:0]  q,
  output logic          qm
);
  logic hit;

  assign hit = (sel == SW'(IDX));
  assign q   = d_acc | (hit ? d : '0);
  assign qm  = m_acc | (hit & m);
endmodule

module mux_scan #(
  parameter int CH    = 4,
  parameter int W     = 1,
  parameter int SW    = 2,
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SW-1:0]    sel_in,
  input  logic [CH-1:0]    mask,
  input  logic [CH*W-1:0]  din,
  output logic [W-1:0]     dout,
  output logic [SW-1:0]    sel_cur,
  output logic             wrap
);
  localparam int SW1 = SW + 1;
  localparam int CW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW:0]   CH_N    = SW1'(CH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  logic [W-1:0]    dacc [0:CH];
  logic            macc [0:CH];
  logic [CH:0]     hit;
  logic [SW-1:0]   off  [0:CH];
  logic [2*CH-1:0] mask2;
  logic [CH-1:0]   rot;
  logic [SW:0]     sum;
  logic [SW-1:0]   nxt;
  logic [CW-1:0]   cnt;

  assign dacc[0] = '0;
  assign macc[0] = 1'b0;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    mux_scan_lane #(.W(W), .SW(SW), .IDX(k)) u_lane (
      .sel   (sel_cur),
      .d     (din[k*W +: W]),
      .m     (mask[k]),
      .d_acc (dacc[k]),
      .m_acc (macc[k]),
      .q     (dacc[k+1]),
      .qm    (macc[k+1])
    );
  end

  // rot[k] is the mask bit of channel (sel_cur+1+k) mod CH, so the lowest
  // set bit of rot is the distance to the next enabled channel.
  assign mask2 = {mask, mask};
  assign rot   = CH'(mask2 >> ({1'b0, sel_cur} + SW1'(1)));

  assign hit[0] = 1'b0;
  assign off[0] = '0;
  for (genvar k = 0; k < CH; k++) begin : g_pri
    assign hit[k+1] = hit[k] | rot[k];
    assign off[k+1] = hit[k] ? off[k] : SW'(k);
  end

  assign sum = {1'b0, sel_cur} + {1'b0, off[CH]} + SW1'(1);
  assign nxt = (sum >= CH_N) ? SW'(sum - CH_N) : SW'(sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout    <= '0;
      sel_cur <= '0;
      cnt     <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (en) begin
        dout <= (mode && !macc[CH]) ? '0 : dacc[CH];
        if (!mode) begin
          cnt <= '0;
          if ({1'b0, sel_in} < CH_N) sel_cur <= sel_in;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
          // hit[CH] is |mask; with nothing enabled the scan parks
          if (hit[CH]) begin
            sel_cur <= nxt;
            wrap    <= (nxt <= sel_cur);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mux_scan.sv
// Randomized bench for mux_scan: two configurations (4ch/W1/dwell2 and 3ch/W2/dwell1)
// compared every cycle against a plain-arithmetic reference model.

module tb_mux_scan;
  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [1:0] sel_in;
  logic [3:0] mask_a, din_a;
  logic [2:0] mask_b;
  logic [5:0] din_b;
  logic       dout_a, wrap_a, wrap_b;
  logic [1:0] sel_a, dout_b, sel_b;

  int checks = 0;
  int passes = 0;
  int ch[2] = '{4, 3};
  int w[2]  = '{1, 2};
  int dw[2] = '{2, 1};
  int m_sel[2], m_cnt[2], m_dout[2], m_wrap[2];

  mux_scan #(.CH(4), .W(1), .SW(2), .DWELL(2)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
    .mask(mask_a), .din(din_a), .dout(dout_a), .sel_cur(sel_a), .wrap(wrap_a));

  mux_scan #(.CH(3), .W(2), .SW(2), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
    .mask(mask_b), .din(din_b), .dout(dout_b), .sel_cur(sel_b), .wrap(wrap_b));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sel[d] = 0; m_cnt[d] = 0; m_dout[d] = 0; m_wrap[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int msk, dat, nx, j;
      msk = (d == 0) ? int'(mask_a) : int'(mask_b);
      dat = (d == 0) ? int'(din_a)  : int'(din_b);
      m_wrap[d] = 0;
      if (en) begin
        m_dout[d] = (dat >> (m_sel[d] * w[d])) & ((1 << w[d]) - 1);
        if (mode && ((msk >> m_sel[d]) & 1) == 0) m_dout[d] = 0;
        if (!mode) begin
          m_cnt[d] = 0;
          if (int'(sel_in) < ch[d]) m_sel[d] = int'(sel_in);
        end else if (m_cnt[d] < dw[d] - 1) begin
          m_cnt[d]++;
        end else begin
          m_cnt[d] = 0;
          nx = -1;
          for (int k = 1; k <= ch[d]; k++) begin
            j = (m_sel[d] + k) % ch[d];
            if (nx < 0 && ((msk >> j) & 1) == 1) nx = j;
          end
          if (nx >= 0) begin
            m_wrap[d] = (nx <= m_sel[d]) ? 1 : 0;
            m_sel[d]  = nx;
          end
        end
      end
    end
  endtask

  function automatic logic [8:0] exp_vec();
    logic [31:0] a0, a1, a2, b0, b1, b2;
    a0 = m_dout[0]; a1 = m_sel[0]; a2 = m_wrap[0];
    b0 = m_dout[1]; b1 = m_sel[1]; b2 = m_wrap[1];
    return {a0[0], a1[1:0], a2[0], b0[1:0], b1[1:0], b2[0]};
  endfunction

  function automatic logic [8:0] act();
    return {dout_a, sel_a, wrap_a, dout_b, sel_b, wrap_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic rand_din();
    din_a = 4'($urandom);
    din_b = 6'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel_in = 2'd0;
    mask_a = 4'hf; mask_b = 3'h7; din_a = 4'hf; din_b = 6'h3f;
    model_reset();
    #2;
    checks++;
    if (act() !== 9'b0) $display("FAIL reset_hold actual=%b required=%b", act(), 9'b0);
    else passes++;
    tick(); tick();
    checks++;
    if (act() !== exp_vec()) $display("FAIL reset_edges actual=%b required=%b", act(), exp_vec());
    else passes++;
    #3 rst = 1'b0;
    din_a = 4'b0001; din_b = 6'b000001;
    tick();
    checks++;
    if (dout_a !== 1'b1 || dout_b !== 2'b01 || sel_a !== 2'd0 || wrap_a !== 1'b0)
      $display("FAIL reset_first_edge actual=%b required=dout_a=1 dout_b=01 sel=0", act());
    else passes++;
  endtask

  task automatic test_manual();
    din_a = 4'b0100; din_b = 6'b100100;
    for (int s = 0; s < 6; s++) begin
      sel_in = 2'(s);
      tick();
      checks++;
      if (act() !== exp_vec()) $display("FAIL manual_sweep s=%0d actual=%b required=%b", s, act(), exp_vec());
      else passes++;
    end
    for (int i = 0; i < 20; i++) begin
      sel_in = 2'($urandom); rand_din();
      tick();
      checks++;
      if (act() !== exp_vec()) $display("FAIL manual_rand i=%0d actual=%b required=%b", i, act(), exp_vec());
      else passes++;
    end
  endtask

  task automatic test_scan();
    mode = 1'b1; mask_a = 4'b1111; mask_b = 3'b111; din_a = 4'b1010;
    for (int i = 0; i < 24; i++) begin
      din_b = 6'($urandom);
      tick();
      checks++;
      if (act() !== exp_vec()) $display("FAIL scan_dwell i=%0d actual=%b required=%b", i, act(), exp_vec());
      else passes++;
    end
  endtask

  task automatic test_masked();
    logic [3:0] ma [3] = '{4'b1010, 4'b0100, 4'b0000};
    logic [2:0] mb [3] = '{3'b101, 3'b010, 3'b000};
    mode = 1'b1;
    for (int p = 0; p < 3; p++) begin
      mask_a = ma[p]; mask_b = mb[p];
      for (int i = 0; i < 10; i++) begin
        rand_din();
        tick();
        checks++;
        if (act() !== exp_vec()) $display("FAIL masked p=%0d i=%0d actual=%b required=%b", p, i, act(), exp_vec());
        else passes++;
      end
    end
  endtask

  task automatic test_stall_mode();
    mode = 1'b1; mask_a = 4'hf; mask_b = 3'h7;
    for (int i = 0; i < 12; i++) begin
      en = (i >= 3 && i < 6) ? 1'b0 : 1'b1;
      if (i == 7) begin mode = 1'b0; sel_in = 2'd3; end
      if (i == 8) mode = 1'b1;
      rand_din();
      tick();
      checks++;
      if (act() !== exp_vec()) $display("FAIL stall_mode i=%0d actual=%b required=%b", i, act(), exp_vec());
      else passes++;
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    mode = 1'b1; mask_a = 4'hf; mask_b = 3'h7; din_a = 4'hf; din_b = 6'h3f;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      checks++;
      if (act() !== exp_vec()) $display("FAIL async_pre i=%0d actual=%b required=%b", i, act(), exp_vec());
      else passes++;
      if (m_sel[0] == 2 && m_cnt[0] == 0) seen = 1;
    end
    checks++;
    if (!seen || sel_a !== 2'd2) $display("FAIL async_reach_ch2 actual=%0d required=2", sel_a);
    else passes++;
    #3 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (act() !== 9'b0) $display("FAIL async_immediate actual=%b required=%b", act(), 9'b0);
    else passes++;
    tick();
    #3 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_din();
      tick();
      checks++;
      if (act() !== exp_vec()) $display("FAIL async_post i=%0d actual=%b required=%b", i, act(), exp_vec());
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(9) != 0);
      if ($urandom_range(15) == 0) mode = ~mode;
      if ($urandom_range(7) == 0) begin mask_a = 4'($urandom); mask_b = 3'($urandom); end
      sel_in = 2'($urandom);
      rand_din();
      tick();
      checks++;
      if (act() !== exp_vec()) $display("FAIL random i=%0d actual=%b required=%b", i, act(), exp_vec());
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_masked();
    test_stall_mode();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
Parametrised N-channel, W-bit registered multiplexer. It succeeds the combinational 4:1 mux with a clocked output, a manual/auto-scan mode, per-channel masking in scan mode, and a wrap strobe. It is used where several sources time-share one downstream path, for example a monitor/probe bus or a serialiser front end.

Parameters:
CH, 4, number of input channels (>=2).
W, 1, data width per channel (>=1).
SW, 2, select width; must satisfy 2**SW >= CH.
DWELL, 1, cycles spent on each channel in scan mode (>=1).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous active-high reset.
en  input  1  clock enable; 0 freezes all state.
mode  input  1  0 = manual select, 1 = auto-scan.
sel_in  input  SW  channel select in manual mode.
mask  input  CH  scan-mode channel enable, bit i = channel i.
din  input  CH*W  packed inputs; channel i occupies din[i*W +: W].
dout  output  W  registered selected data.
sel_cur  output  SW  current channel index.
wrap  output  1  one-cycle pulse when the scan wraps to a lower-or-equal index.

Behaviour:
- Reset (asynchronous, any time including mid-scan): dout=0, sel_cur=0, dwell counter=0, wrap=0. The first update happens on the first rising edge after rst deasserts.
- en=0: dout, sel_cur and the dwell counter hold their values; wrap=0.
- Datapath (en=1): dout <= din[sel_cur*W +: W], using the pre-edge sel_cur. Latency is 1 cycle from din/sel_cur to dout.
- Scan-mode masking: if mode=1 and mask[sel_cur]=0, dout <= 0 instead of the channel data.
- Manual mode (mode=0, en=1):
  - sel_cur <= sel_in when sel_in < CH; otherwise sel_cur holds.
  - Dwell counter is forced to 0; wrap=0.
- Scan mode (mode=1, en=1):
  - The dwell counter counts 0..DWELL-1.
  - If counter < DWELL-1: counter increments and sel_cur holds.
  - If counter == DWELL-1: counter <= 0, and sel_cur advances to the next index j with mask[j]=1, searching sel_cur+1, sel_cur+2, ... modulo CH.
  - If the only unmasked channel is sel_cur itself, sel_cur stays.
  - If mask == 0, sel_cur holds, dout outputs 0, and wrap=0.
- wrap: registered; =1 for exactly the cycle after an advance whose new index <= old index. This includes the single-unmasked-channel case, which pulses once per DWELL cycles.
- Mode change 0->1: scanning starts from the current sel_cur with counter=0; the first advance occurs after DWELL enabled cycles.
- Mode change 1->0: on the next edge sel_cur <= sel_in (if in range); counter cleared.
- Mask change mid-dwell: takes effect at the next advance. The current channel completes its dwell even if it is now masked; its data is zeroed on dout.
- CH not a power of two: sel_cur never exceeds CH-1 in either mode.

Test Plan:
- Reset/idle: rst=1 then released, en=1, mode=0, sel_in=0, din=4'b0001 (CH=4, W=1) -> after reset dout=0, sel_cur=0, wrap=0; one edge later dout=1.
- Manual sweep: din=4'b0100, sel_in stepped 0,1,2,3 one per cycle -> sel_cur follows one cycle later; dout=0,0,1,0 lagging sel_cur by one cycle.
- Scan with dwell: CH=4, DWELL=2, mask=4'b1111, din=4'b1010 -> sel_cur 0,0,1,1,2,2,3,3,0,...; dout 0,0,1,1,0,0,1,1 delayed one cycle; wrap high for one cycle after the 3->0 transition, every 8 cycles.
- Masked scan: DWELL=1, mask=4'b1010 -> sel_cur alternates 1,3,1,3; wrap pulses after each 3->1. With mask=4'b0100, sel_cur goes to 2 and stays; wrap pulses every cycle. With mask=0, sel_cur frozen, dout=0, wrap=0.
- Stall and mode switch: en=0 for 3 cycles mid-scan -> all outputs frozen, wrap=0. Switch to mode=0 with sel_in=3 -> sel_cur=3 next edge. Switch back to mode=1 -> first advance to 0 after DWELL cycles, with a wrap pulse.
- Async reset mid-scan: assert rst between clock edges while sel_cur=2 -> dout, sel_cur and wrap go to 0 immediately, without waiting for a clock edge; after release, scanning restarts from channel 0.
